calc_sequencer: RTL
===================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 16, the maximum number of cycles spent waiting in CMP_WAIT or ALU_RUN.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  a request word is present.
- req_code  in  12  [11:8] first operand, [7:4] second operand, [3:0] operation.
- req_ready  out  1  the block can accept a request.
- cmp_sel  out  1  complement stage select.
- cmp_wr_enable  out  1  complement stage load strobe.
- cmp_code  out  12  request word forwarded to the complement stage.
- cmp_finish  in  1  the complement stage has finished.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_done  in  1  the ALU result is valid.
- alu_result  in  8  ALU result.
- res_valid  out  1  a response is present.
- res_ready  in  1  the consumer accepts the response.
- res_data  out  8  result value.
- res_err  out  1  the response is an error.
- busy  out  1  the FSM is not in IDLE.
- err_cnt  out  8  saturating count of error responses.
REQ-003 Clock and reset: one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, LOAD, CMP_WAIT, ALU_RUN, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE with rst low; busy SHALL be 1 in every state except IDLE.
REQ-006 A handshake (req_valid & req_ready) in IDLE SHALL capture req_code into an internal register.
REQ-007 Legal operation codes SHALL be 4'h1 add, 4'h2 sub, 4'h3 mul, 4'h4 div; any other code SHALL go IDLE -> RESP with res_err=1 and res_data=8'h00, and the datapath SHALL NOT be touched.
REQ-008 Operation 4'h4 with a second operand of 4'h0 SHALL be treated as an error, exactly as in REQ-007.
REQ-009 A legal request SHALL go IDLE -> LOAD; in LOAD, cmp_sel=1 and cmp_wr_enable=1 for exactly one cycle, and cmp_code = the captured word.
REQ-010 LOAD SHALL go unconditionally to CMP_WAIT.
REQ-011 In CMP_WAIT, cmp_sel SHALL stay 1 and cmp_wr_enable SHALL be 0.
REQ-012 cmp_code SHALL hold the captured word from LOAD until the FSM returns to IDLE.
REQ-013 In CMP_WAIT, cmp_finish=1 SHALL move the FSM to ALU_RUN; alu_start SHALL be 1 only in the first ALU_RUN cycle.
REQ-014 cmp_sel SHALL be 0 in IDLE, ALU_RUN and RESP.
REQ-015 In ALU_RUN, alu_done=1 SHALL register alu_result into res_data, set res_err=0 and move to RESP.
REQ-016 alu_done asserted in the alu_start cycle SHALL be honoured.
REQ-017 A wait counter SHALL clear on every entry to CMP_WAIT or ALU_RUN and increment each cycle spent in that state.
REQ-018 When the wait counter reaches TIMEOUT-1 with no finish or done, the next state SHALL be RESP with res_err=1 and res_data=8'hFF.
REQ-019 If finish or done coincides with the timeout cycle, the finish or done SHALL win.
REQ-020 In RESP, res_valid=1 and res_data/res_err SHALL stay stable until res_ready=1; res_ready=1 SHALL return the FSM to IDLE.
REQ-021 The earliest new request is the cycle after the FSM re-enters IDLE; there is no back-to-back bypass.
REQ-022 res_valid SHALL be 0 in every state other than RESP.
REQ-023 err_cnt SHALL increment by 1 on each accepted response with res_err=1 and SHALL saturate at 8'hFF.
REQ-024 cmp_finish and alu_done SHALL be ignored in any state where they are not awaited.
REQ-025 Minimum latency for a legal request accepted in cycle 0, with finish in cycle 2 and done in cycle 3: res_valid=1 in cycle 4.
REQ-026 For an illegal request accepted in cycle 0, res_valid SHALL be 1 in cycle 1.

Reset
REQ-027 While rst=1 at a clock edge, the FSM SHALL go to IDLE regardless of its current state.
REQ-028 Reset SHALL set every output to 0: req_ready, cmp_sel, cmp_wr_enable, cmp_code, alu_start, res_valid, res_data, res_err, busy, err_cnt.
REQ-029 Reset SHALL clear the captured word and the wait counter.
REQ-030 Reset asserted mid-operation SHALL abort the operation without producing a response; req_ready SHALL be 1 in the first cycle with rst low.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- req_code=12'h351 (3+5 add); cmp_finish 2 cycles after LOAD; alu_done with alu_result=8'h08 -> res_valid with res_data=8'h08, res_err=0; one alu_start pulse; one cmp_wr_enable pulse.
- req_code=12'h347 (op 7) -> res_valid in the cycle after accept, res_err=1, res_data=8'h00, cmp_sel never 1, err_cnt=1.
- req_code=12'h904 (div by 0) -> error response as above; err_cnt increments.
- cmp_finish never asserted, TIMEOUT=16 -> RESP 16 cycles after CMP_WAIT entry, res_err=1, res_data=8'hFF.
- res_ready held 0 for 5 cycles in RESP -> res_valid, res_data and res_err stable; req_ready=0 throughout.
- rst pulsed in ALU_RUN -> all outputs 0 next cycle, no response emitted, req_ready=1 after rst deasserts; 256 forced errors -> err_cnt stays at 8'hFF.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer -- sequences one arithmetic request through a complement
// stage and an ALU, then presents a response until the consumer takes it.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   req_valid/req_ready       request handshake, req_code = {a, b, op}
//   cmp_sel, cmp_wr_enable    complement stage select / one-cycle load strobe
//   cmp_code                  captured request word for the complement stage
//   cmp_finish                complement stage finished (awaited in CMP_WAIT)
//   alu_start                 one-cycle ALU start pulse
//   alu_done, alu_result      ALU completion and result (awaited in ALU_RUN)
//   res_valid/res_ready       response handshake, res_data / res_err payload
//   busy                      FSM not idle
//   err_cnt                   saturating count of accepted error responses
module calc_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [11:0] req_code,
  output logic        req_ready,
  output logic        cmp_sel,
  output logic        cmp_wr_enable,
  output logic [11:0] cmp_code,
  input  logic        cmp_finish,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [7:0]  alu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_err,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    CMP_WAIT = 3'd2,
    ALU_RUN  = 3'd3,
    RESP     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [11:0]   word_q, word_d;
  logic          loaded_q, loaded_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [7:0]    res_data_q, res_data_d;
  logic          res_err_q, res_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [3:0] req_op;
  logic [3:0] req_b;
  logic       req_legal;
  logic       timed_out;

  assign req_op    = req_code[3:0];
  assign req_b     = req_code[7:4];
  // Division by zero is rejected up front, like an unknown opcode.
  assign req_legal = (req_op >= 4'h1) && (req_op <= 4'h4) &&
                     !((req_op == 4'h4) && (req_b == 4'h0));
  assign timed_out = (wait_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    loaded_d   = loaded_q;
    wait_d     = wait_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          word_d = req_code;
          if (req_legal) begin
            state_d  = LOAD;
            loaded_d = 1'b1;
          end else begin
            state_d    = RESP;
            res_data_d = '0;
            res_err_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        state_d = CMP_WAIT;
        wait_d  = '0;
      end
      CMP_WAIT: begin
        // Completion takes priority over a timeout in the same cycle.
        if (cmp_finish) begin
          state_d = ALU_RUN;
          wait_d  = '0;
        end else if (timed_out) begin
          state_d    = RESP;
          res_data_d = '1;
          res_err_d  = 1'b1;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      ALU_RUN: begin
        if (alu_done) begin
          state_d    = RESP;
          res_data_d = alu_result;
          res_err_d  = 1'b0;
        end else if (timed_out) begin
          state_d    = RESP;
          res_data_d = '1;
          res_err_d  = 1'b1;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d  = IDLE;
          loaded_d = 1'b0;
          if (res_err_q && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      loaded_q   <= 1'b0;
      wait_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      loaded_q   <= loaded_d;
      wait_q     <= wait_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign req_ready     = (state_q == IDLE) && !rst;
  assign busy          = (state_q != IDLE);
  assign cmp_sel       = (state_q == LOAD) || (state_q == CMP_WAIT);
  assign cmp_wr_enable = (state_q == LOAD);
  // Only legal requests reach the complement stage; rejected words stay hidden.
  assign cmp_code      = loaded_q ? word_q : '0;
  // The wait counter is cleared on ALU_RUN entry, so zero marks its first cycle.
  assign alu_start     = (state_q == ALU_RUN) && (wait_q == '0);
  assign res_valid     = (state_q == RESP);
  assign res_data      = res_data_q;
  assign res_err       = res_err_q;
  assign err_cnt       = err_cnt_q;

endmodule
